// File: rtl/lcd_frame_controller.sv
// HD44780 16x2 sequencer: power-up init, then DDRAM address + 32 data bytes per accepted frame.
// Optional LCD_COALESCE_EN: requests arriving while busy collapse into one follow-on frame.
module lcd_frame_controller #(
  parameter int unsigned EN_CYCLES    = 16,
  parameter int unsigned CMD_WAIT     = 2000,
  parameter int unsigned CLEAR_WAIT   = 82000,
  parameter int unsigned POWERUP_WAIT = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ASCII [32],
  input  logic       UpdateLCD,
  output logic       LCDBusy,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_ON,
  output logic       LCD_BLON
);

  // state   | meaning
  // PWRUP   | waiting POWERUP_WAIT after reset release
  // INIT    | sending 0x38, 0x0C, 0x06, 0x01
  // IDLE    | ready, LCDBusy low, waiting for UpdateLCD
  // ADDR1   | sending DDRAM address 0x80
  // LINE1   | sending buffer[0..15]
  // ADDR2   | sending DDRAM address 0xC0
  // LINE2   | sending buffer[16..31]
  // bstate  | SETUP -> PULSE (EN high) -> HOLD -> WAIT, once per byte
  typedef enum logic [2:0] {PWRUP, INIT, IDLE, ADDR1, LINE1, ADDR2, LINE2} state_t;
  typedef enum logic [1:0] {B_SETUP, B_PULSE, B_HOLD, B_WAIT} bstate_t;

  localparam int unsigned TMAX_A = (EN_CYCLES > CMD_WAIT) ? EN_CYCLES : CMD_WAIT;
  localparam int unsigned TMAX_B = (CLEAR_WAIT > POWERUP_WAIT) ? CLEAR_WAIT : POWERUP_WAIT;
  localparam int unsigned TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
  localparam int          TW     = $clog2(TMAX + 1);

  localparam logic [TW-1:0] EN_LOAD    = TW'(EN_CYCLES - 1);
  localparam logic [TW-1:0] CMD_LOAD   = TW'(CMD_WAIT - 1);
  localparam logic [TW-1:0] CLEAR_LOAD = TW'(CLEAR_WAIT - 1);
  localparam logic [TW-1:0] PWRUP_LOAD = TW'(POWERUP_WAIT - 1);

  state_t        state;
  bstate_t       bstate;
  logic [TW-1:0] timer;
  logic [1:0]    init_idx;
  logic [3:0]    char_idx;
  logic [7:0]    frame_buf [32];

  state_t        nxt_state;
  logic [7:0]    nxt_data;
  logic          nxt_rs;
  logic [1:0]    nxt_init_idx;
  logic [3:0]    nxt_char_idx;
  logic          nxt_latch;
  logic          frame_end;
  logic          coalesce_req;
  logic [3:0]    char_inc;
  logic [1:0]    init_inc;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

`ifdef LCD_COALESCE_EN
  logic pending;
  assign coalesce_req = pending | UpdateLCD;
`else
  assign coalesce_req = 1'b0;
`endif

  assign LCD_RW   = 1'b0;
  assign LCD_ON   = 1'b1;
  assign LCD_BLON = 1'b1;

  assign char_inc = char_idx + 4'd1;
  assign init_inc = init_idx + 2'd1;

  // What follows the byte currently finishing its WAIT phase.
  always_comb begin
    nxt_state    = state;
    nxt_data     = 8'h00;
    nxt_rs       = 1'b0;
    nxt_init_idx = init_idx;
    nxt_char_idx = char_idx;
    nxt_latch    = 1'b0;
    frame_end    = 1'b0;
    case (state)
      INIT: begin
        if (init_idx == 2'd3) begin
          frame_end = 1'b1;
        end else begin
          nxt_init_idx = init_inc;
          nxt_data     = init_cmd(init_inc);
        end
      end
      ADDR1: begin
        nxt_state    = LINE1;
        nxt_char_idx = 4'd0;
        nxt_data     = frame_buf[5'd0];
        nxt_rs       = 1'b1;
      end
      LINE1: begin
        nxt_char_idx = char_inc;
        if (char_idx == 4'd15) begin
          nxt_state = ADDR2;
          nxt_data  = 8'hC0;
        end else begin
          nxt_data = frame_buf[{1'b0, char_inc}];
          nxt_rs   = 1'b1;
        end
      end
      ADDR2: begin
        nxt_state    = LINE2;
        nxt_char_idx = 4'd0;
        nxt_data     = frame_buf[5'd16];
        nxt_rs       = 1'b1;
      end
      LINE2: begin
        nxt_char_idx = char_inc;
        if (char_idx == 4'd15) begin
          frame_end = 1'b1;
        end else begin
          nxt_data = frame_buf[{1'b1, char_inc}];
          nxt_rs   = 1'b1;
        end
      end
      default: ;
    endcase
    if (frame_end) begin
      if (coalesce_req) begin
        nxt_state    = ADDR1;
        nxt_data     = 8'h80;
        nxt_rs       = 1'b0;
        nxt_char_idx = 4'd0;
        nxt_latch    = 1'b1;
      end else begin
        nxt_state = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= PWRUP;
      bstate   <= B_SETUP;
      timer    <= PWRUP_LOAD;
      init_idx <= 2'd0;
      char_idx <= 4'd0;
      LCDBusy  <= 1'b1;
      LCD_DATA <= 8'h00;
      LCD_RS   <= 1'b0;
      LCD_EN   <= 1'b0;
      for (int i = 0; i < 32; i++) frame_buf[i] <= 8'h20;
`ifdef LCD_COALESCE_EN
      pending  <= 1'b0;
`endif
    end else begin
`ifdef LCD_COALESCE_EN
      if (UpdateLCD && state != IDLE) pending <= 1'b1;
`endif
      case (state)
        PWRUP: begin
          if (timer == '0) begin
            state    <= INIT;
            init_idx <= 2'd0;
            bstate   <= B_SETUP;
            LCD_DATA <= init_cmd(2'd0);
            LCD_RS   <= 1'b0;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        IDLE: begin
          if (UpdateLCD) begin
            for (int i = 0; i < 32; i++) frame_buf[i] <= ASCII[i];
            state    <= ADDR1;
            bstate   <= B_SETUP;
            LCD_DATA <= 8'h80;
            LCD_RS   <= 1'b0;
            LCDBusy  <= 1'b1;
          end
        end
        default: begin
          case (bstate)
            B_SETUP: begin
              bstate <= B_PULSE;
              LCD_EN <= 1'b1;
              timer  <= EN_LOAD;
            end
            B_PULSE: begin
              if (timer == '0) begin
                bstate <= B_HOLD;
                LCD_EN <= 1'b0;
              end else begin
                timer <= timer - TW'(1);
              end
            end
            B_HOLD: begin
              bstate <= B_WAIT;
              // clear-display needs the long settle
              timer  <= (!LCD_RS && LCD_DATA == 8'h01) ? CLEAR_LOAD : CMD_LOAD;
            end
            default: begin
              if (timer != '0) begin
                timer <= timer - TW'(1);
              end else begin
                state    <= nxt_state;
                init_idx <= nxt_init_idx;
                char_idx <= nxt_char_idx;
                bstate   <= B_SETUP;
                if (nxt_state == IDLE) begin
                  LCDBusy <= 1'b0;
                end else begin
                  LCD_DATA <= nxt_data;
                  LCD_RS   <= nxt_rs;
                end
                if (nxt_latch) begin
                  for (int i = 0; i < 32; i++) frame_buf[i] <= ASCII[i];
`ifdef LCD_COALESCE_EN
                  pending <= 1'b0;
`endif
                end
              end
            end
          endcase
        end
      endcase
    end
  end

endmodule
